// File: rtl/lift53_pkg.sv
// lift53_pkg -- shared constants for the 5/3 lifting pipeline.
//   step encodings   : STEP_PREDICT (odd samples), STEP_UPDATE (even samples)
//   rounding offsets : added to the neighbour sum before the floor shift
//   shift amounts    : divide-by-2 (predict) and divide-by-4 (update)
//   needs_saturation : width-independent range test on the top three bits of a
//                      W+2-bit signed value
package lift53_pkg;

   typedef enum logic {
      STEP_PREDICT = 1'b0,
      STEP_UPDATE  = 1'b1
   } step_e;

   localparam int RND_PREDICT   = 0;
   localparam int RND_UPDATE    = 2;
   localparam int SHIFT_PREDICT = 1;
   localparam int SHIFT_UPDATE  = 2;

   // A W+2-bit signed value fits in W bits only when its three most
   // significant bits are all equal (pure sign extension).
   function automatic logic needs_saturation(input logic [2:0] msbs);
      return !((msbs == 3'b000) || (msbs == 3'b111));
   endfunction

endpackage

// File: rtl/lift53_pipe_if.sv
// lift53_pipe_if -- bus bundle for lift53_pipe.
//   Input beat  : in_valid/in_ready, x_left, x_center, x_right, step, fwd_res, in_last
//   Output beat : out_valid/out_ready, y, out_last
//   Status      : ovf (sticky), ovf_clr, line_cnt
// Handshake: a beat moves across a channel on a rising clock edge where both
// valid and ready are high. A producer holding valid high keeps its payload
// stable until that edge; ready never depends on the same channel's valid.
// modport slave  : the lifting pipeline's view.
// modport master : the surrounding system's (or bench's) view.
interface lift53_pipe_if #(
   parameter int W     = 24,
   parameter int CNT_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [W-1:0]  x_left;
   logic signed [W-1:0]  x_center;
   logic signed [W-1:0]  x_right;
   logic                 step;
   logic                 fwd_res;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [W-1:0]  y;
   logic                 out_last;
   logic                 ovf;
   logic                 ovf_clr;
   logic [CNT_W-1:0]     line_cnt;

   modport slave (
      input  in_valid, x_left, x_center, x_right, step, fwd_res, in_last,
      input  out_ready, ovf_clr,
      output in_ready, out_valid, y, out_last, ovf, line_cnt
   );

   modport master (
      output in_valid, x_left, x_center, x_right, step, fwd_res, in_last,
      output out_ready, ovf_clr,
      input  in_ready, out_valid, y, out_last, ovf, line_cnt
   );
endinterface

// File: rtl/lift53_sat.sv
// lift53_sat -- clamps a W+2-bit signed value into W bits.
//   din  : W+2-bit signed input
//   dout : W-bit signed result, clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf  : high when clamping changed the value
module lift53_sat
   import lift53_pkg::*;
#(
   parameter int W = 24
) (
   input  logic signed [W+1:0] din,
   output logic signed [W-1:0] dout,
   output logic                ovf
);

   localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   always_comb begin
      ovf = needs_saturation(din[W+1:W-1]);
      if (!ovf) begin
         dout = din[W-1:0];
      end else if (din[W+1]) begin
         dout = MIN_VAL;
      end else begin
         dout = MAX_VAL;
      end
   end

endmodule

// File: rtl/lift53_pipe.sv
// lift53_pipe -- two-stage 5/3 integer lifting step (predict or update,
// forward or inverse) with saturation, sticky overflow and a per-line
// output beat counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lift53_pipe_if.slave (input beat, output beat, status)
// Stage 1 registers the rounded neighbour sum with the centre sample and the
// per-beat mode bits; stage 2 applies the floor shift, the add/sub and the
// clamp, and registers y. Each stage only advances when the stage after it
// can take its contents, so a stall freezes the output register in place.
module lift53_pipe
   import lift53_pkg::*;
#(
   parameter int W     = 24,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   lift53_pipe_if.slave bus
);

   // Stage 1 state
   logic                s1_valid;
   logic signed [W+1:0] s1_sum;
   logic signed [W-1:0] s1_center;
   logic                s1_step;
   logic                s1_fwd;
   logic                s1_last;

   // Stage 2 (output register) state
   logic                out_valid_q;
   logic signed [W-1:0] y_q;
   logic                out_last_q;
   logic                ovf_q;
   logic [CNT_W-1:0]    line_cnt_q;

   // Flow control
   logic s2_load;
   logic s1_load;

   // Datapath
   logic signed [W+1:0] rnd;
   logic signed [W+1:0] pair_sum;
   logic signed [W+1:0] delta;
   logic signed [W+1:0] center_x;
   logic signed [W+1:0] pre_sat;
   logic                add_delta;
   logic signed [W-1:0] sat_y;
   logic                sat_ovf;

   assign s2_load = !out_valid_q || bus.out_ready;
   assign s1_load = !s1_valid || s2_load;

   // ------------------------------------------------------------------
   // Stage 1 combinational: neighbour sum plus rounding offset, in W+2
   // bits so the sum of two extreme samples plus 2 cannot wrap.
   // ------------------------------------------------------------------
   always_comb begin
      rnd = (bus.step == STEP_UPDATE) ? (W+2)'(RND_UPDATE) : (W+2)'(RND_PREDICT);
      pair_sum = {{2{bus.x_left[W-1]}},  bus.x_left}
               + {{2{bus.x_right[W-1]}}, bus.x_right}
               + rnd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         s1_center <= '0;
         s1_step   <= 1'b0;
         s1_fwd    <= 1'b0;
         s1_last   <= 1'b0;
      end else if (s1_load) begin
         s1_valid  <= bus.in_valid;
         s1_sum    <= pair_sum;
         s1_center <= bus.x_center;
         s1_step   <= bus.step;
         s1_fwd    <= bus.fwd_res;
         s1_last   <= bus.in_last;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 combinational: arithmetic shift gives floor division for
   // negative sums too. Predict subtracts in the forward direction and
   // adds in the inverse; update does the opposite.
   // ------------------------------------------------------------------
   always_comb begin
      if (s1_step == STEP_UPDATE) begin
         delta     = s1_sum >>> SHIFT_UPDATE;
         add_delta = s1_fwd;
      end else begin
         delta     = s1_sum >>> SHIFT_PREDICT;
         add_delta = !s1_fwd;
      end
      center_x = {{2{s1_center[W-1]}}, s1_center};
      pre_sat  = add_delta ? (center_x + delta) : (center_x - delta);
   end

   lift53_sat #(.W(W)) u_sat (
      .din  (pre_sat),
      .dout (sat_y),
      .ovf  (sat_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         out_last_q  <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            y_q        <= sat_y;
            out_last_q <= s1_last;
         end
      end
   end

   // Sticky overflow: a saturated beat entering the output register takes
   // priority over a simultaneous clear, so no overflow event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (s2_load && s1_valid && sat_ovf) begin
         ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   // Counts output transfers within a line; the last beat of a line
   // returns it to zero. Free-running wrap at the counter width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_cnt_q <= '0;
      end else if (out_valid_q && bus.out_ready) begin
         if (out_last_q) begin
            line_cnt_q <= '0;
         end else begin
            line_cnt_q <= line_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.in_ready  = s1_load;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.out_last  = out_last_q;
   assign bus.ovf       = ovf_q;
   assign bus.line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_lift53_pipe.sv
// tb_lift53_pipe -- self-checking bench for lift53_pipe.
// Directed vector table, hand-written corner sequences (overflow clear,
// set-wins, stall, line counter, mid-stream reset) and a randomized stream
// checked by a scoreboard fed from an arithmetic reference model.
module tb_lift53_pipe;

   localparam int W     = 24;
   localparam int CNT_W = 16;
   localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (W-1));

   logic clk;
   logic rst_n;

   lift53_pipe_if #(.W(W), .CNT_W(CNT_W)) bus ();

   lift53_pipe #(.W(W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters / scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   int n_out    = 0;
   bit any_sat  = 1'b0;

   logic [W:0]       exp_q[$];          // {last, y}
   logic [CNT_W-1:0] exp_cnt = '0;
   bit               prev_stall = 1'b0;
   logic signed [W-1:0] prev_y;
   logic             prev_last;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint floor_div(input longint a, input longint b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic void ref_lift(input longint l, input longint c, input longint r,
                                    input logic stp, input logic fwd,
                                    output longint y, output logic sat);
      longint t;
      longint v;
      if (stp == 1'b0) begin
         t = floor_div(l + r, 2);
         v = fwd ? (c - t) : (c + t);
      end else begin
         t = floor_div(l + r + 2, 4);
         v = fwd ? (c + t) : (c - t);
      end
      sat = 1'b0;
      if (v > MAXV) begin
         v = MAXV; sat = 1'b1;
      end else if (v < MINV) begin
         v = MINV; sat = 1'b1;
      end
      y = v;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      longint ym;
      logic   sm;
      logic [W:0] e;
      logic   e_last;
      if (!rst_n) begin
         exp_q.delete();
         exp_cnt    = '0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", longint'(bus.out_valid), 1);
            check("stall_y", longint'(bus.y), longint'(prev_y));
            check("stall_last", longint'(bus.out_last), longint'(prev_last));
         end
         check("line_cnt", longint'(bus.line_cnt), longint'(exp_cnt));
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            e_last = bus.out_last;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               e_last = e[W];
               check("sb_y", longint'(bus.y), longint'($signed(e[W-1:0])));
               check("sb_last", longint'(bus.out_last), longint'(e[W]));
            end
            exp_cnt = e_last ? '0 : exp_cnt + 1'b1;
         end
         if (bus.in_valid && bus.in_ready) begin
            ref_lift(longint'(bus.x_left), longint'(bus.x_center), longint'(bus.x_right),
                     bus.step, bus.fwd_res, ym, sm);
            exp_q.push_back({bus.in_last, ym[W-1:0]});
            if (sm) any_sat = 1'b1;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_y     = bus.y;
         prev_last  = bus.out_last;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.x_left   = '0;
      bus.x_center = '0;
      bus.x_right  = '0;
      bus.step     = 1'b0;
      bus.fwd_res  = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic signed [W-1:0] l, input logic signed [W-1:0] c,
                           input logic signed [W-1:0] r, input logic stp,
                           input logic fwd, input logic last);
      bus.x_left   = l;
      bus.x_center = c;
      bus.x_right  = r;
      bus.step     = stp;
      bus.fwd_res  = fwd;
      bus.in_last  = last;
   endtask

   // Entered just after a rising edge with an empty pipeline and
   // out_ready high; returns at the falling edge where the result is shown.
   task automatic drive_single(input string tag,
                               input logic signed [W-1:0] l, input logic signed [W-1:0] c,
                               input logic signed [W-1:0] r, input logic stp,
                               input logic fwd, input logic last);
      set_beat(l, c, r, stp, fwd, last);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check({tag, "_lat1"}, longint'(bus.out_valid), 0);
      next_cycle();
      @(negedge clk);
      check({tag, "_lat2"}, longint'(bus.out_valid), 1);
   endtask

   task automatic pulse_clr(input string tag);
      bus.ovf_clr = 1'b1;
      next_cycle();
      bus.ovf_clr = 1'b0;
      @(negedge clk);
      check(tag, longint'(bus.ovf), 0);
      next_cycle();
   endtask

   function automatic logic signed [W-1:0] rand_sample();
      int unsigned sel;
      logic [31:0] u;
      sel = $urandom_range(0, 9);
      u   = $urandom();
      if (sel == 0) return MINV[W-1:0];
      if (sel == 1) return MAXV[W-1:0];
      if (sel < 5) begin
         u = 32'($urandom_range(0, 400)) - 32'd200;
      end
      return u[W-1:0];
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic signed [W-1:0] l;
      logic signed [W-1:0] c;
      logic signed [W-1:0] r;
      logic                stp;
      logic                fwd;
      logic signed [W-1:0] y;
      logic                ovf;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int sent;
      int out_base;
      int stall_ready_exp[7];
      logic signed [W-1:0] mn;
      logic signed [W-1:0] mx;
      bit pending;
      int cyc;

      mn = MINV[W-1:0];
      mx = MAXV[W-1:0];
      //            l     c        r     step fwd  y        ovf
      vecs[0]  = '{24'sd80, 24'sd120, 24'sd164, 1'b0, 1'b1, -24'sd2, 1'b0};
      vecs[1]  = '{24'sd80, -24'sd2, 24'sd164, 1'b0, 1'b0, 24'sd120, 1'b0};
      vecs[2]  = '{-24'sd2, 24'sd80, -24'sd2, 1'b1, 1'b1, 24'sd79, 1'b0};
      vecs[3]  = '{-24'sd2, 24'sd79, -24'sd2, 1'b1, 1'b0, 24'sd80, 1'b0};
      vecs[4]  = '{24'sd100, 24'sd8388600, 24'sd100, 1'b0, 1'b0, mx, 1'b1};
      vecs[5]  = '{mn, mn, mn, 1'b1, 1'b1, mn, 1'b1};
      vecs[6]  = '{-24'sd3, 24'sd0, 24'sd0, 1'b0, 1'b1, 24'sd2, 1'b0};
      vecs[7]  = '{-24'sd3, 24'sd5, 24'sd0, 1'b1, 1'b1, 24'sd4, 1'b0};
      vecs[8]  = '{mx, mn, mx, 1'b0, 1'b1, mn, 1'b1};
      vecs[9]  = '{mx, mx, mx, 1'b1, 1'b1, mx, 1'b1};
      vecs[10] = '{24'sd7, -24'sd7, -24'sd8, 1'b1, 1'b0, -24'sd7, 1'b0};
      vecs[11] = '{-24'sd1, 24'sd100, -24'sd2, 1'b0, 1'b0, 24'sd98, 1'b0};

      // ---- reset ----
      rst_n = 1'b0;
      idle_inputs();
      bus.out_ready = 1'b1;
      bus.ovf_clr   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", longint'(bus.in_ready), 1);
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_y", longint'(bus.y), 0);
      check("rst_out_last", longint'(bus.out_last), 0);
      check("rst_ovf", longint'(bus.ovf), 0);
      check("rst_line_cnt", longint'(bus.line_cnt), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", longint'(bus.in_ready), 1);
      next_cycle();

      // ---- vector table ----
      for (int i = 0; i < 12; i++) begin
         pulse_clr($sformatf("vec%0d_clr", i));
         drive_single($sformatf("vec%0d", i), vecs[i].l, vecs[i].c, vecs[i].r,
                      vecs[i].stp, vecs[i].fwd, 1'b0);
         check($sformatf("vec%0d_y", i), longint'(bus.y), longint'(vecs[i].y));
         check($sformatf("vec%0d_ovf", i), longint'(bus.ovf), longint'(vecs[i].ovf));
         next_cycle();
      end
      // close the line left open by the table beats
      drive_single("close_line", 24'sd0, 24'sd0, 24'sd0, 1'b0, 1'b1, 1'b1);
      next_cycle();

      // ---- saturating load and clear in the same cycle: set wins ----
      pulse_clr("setwins_pre_clr");
      set_beat(24'sd100, 24'sd8388600, 24'sd100, 1'b0, 1'b0, 1'b1);
      bus.in_valid = 1'b1;
      next_cycle();
      idle_inputs();
      bus.ovf_clr = 1'b1;
      next_cycle();
      bus.ovf_clr = 1'b0;
      @(negedge clk);
      check("setwins_valid", longint'(bus.out_valid), 1);
      check("setwins_ovf", longint'(bus.ovf), 1);
      next_cycle();
      pulse_clr("setwins_post_clr");

      // ---- line counter: 6-beat line, then next line ----
      for (int k = 1; k <= 8; k++) begin
         drive_single($sformatf("line%0d", k), 24'(k), 24'(k * 10), -24'(k),
                      k[0], 1'b1, (k == 6));
         next_cycle();
         check($sformatf("line%0d_cnt", k), longint'(bus.line_cnt),
               (k < 6) ? k : ((k == 6) ? 0 : k - 6));
      end
      // terminate the second line
      drive_single("line_end", 24'sd1, 24'sd1, 24'sd1, 1'b0, 1'b1, 1'b1);
      next_cycle();
      check("line_end_cnt", longint'(bus.line_cnt), 0);

      // ---- stall: 8 beats, out_ready low in cycles 3..5 ----
      stall_ready_exp = '{1, 1, 1, 0, 0, 0, 1};
      sent     = 0;
      out_base = n_out;
      for (int c = 0; c < 40 && !(sent == 8 && exp_q.size() == 0); c++) begin
         bus.out_ready = !(c >= 3 && c <= 5);
         if (sent < 8) begin
            set_beat(24'(sent * 10), 24'(sent * 100), -24'(sent * 3),
                     sent[0], 1'b1, (sent == 7));
            bus.in_valid = 1'b1;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         if (c >= 2 && c <= 6)
            check($sformatf("stall_in_ready_c%0d", c), longint'(bus.in_ready),
                  stall_ready_exp[c]);
         if (bus.in_valid && bus.in_ready) sent++;
         next_cycle();
      end
      idle_inputs();
      bus.out_ready = 1'b1;
      check("stall_sent", sent, 8);
      check("stall_received", n_out - out_base, 8);
      check("stall_queue_empty", exp_q.size(), 0);

      // ---- randomized stream ----
      pulse_clr("rand_pre_clr");
      any_sat  = 1'b0;
      sent     = 0;
      pending  = 1'b0;
      out_base = n_out;
      for (cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
         if (!pending && $urandom_range(0, 9) < 7) begin
            set_beat(rand_sample(), rand_sample(), rand_sample(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0));
            pending = 1'b1;
         end
         bus.in_valid  = pending;
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (pending && bus.in_ready) begin
            pending = 1'b0;
            sent++;
         end
         next_cycle();
      end
      idle_inputs();
      bus.out_ready = 1'b1;
      for (int d = 0; d < 50 && exp_q.size() != 0; d++) next_cycle();
      repeat (2) next_cycle();
      check("rand_sent", sent, 300);
      check("rand_received", n_out - out_base, 300);
      check("rand_drain", exp_q.size(), 0);
      check("rand_ovf", longint'(bus.ovf), longint'(any_sat));

      // ---- reset with two beats in flight ----
      set_beat(24'sd1, 24'sd2, 24'sd3, 1'b0, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      next_cycle();
      set_beat(24'sd4, 24'sd5, 24'sd6, 1'b1, 1'b1, 1'b0);
      next_cycle();
      idle_inputs();
      check("inflight_valid", longint'(bus.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", longint'(bus.out_valid), 0);
      check("mid_rst_in_ready", longint'(bus.in_ready), 1);
      check("mid_rst_y", longint'(bus.y), 0);
      check("mid_rst_line_cnt", longint'(bus.line_cnt), 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_base = n_out;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         if (bus.out_valid) n_out++;
      end
      check("no_stale_beats", n_out - out_base, 0);
      next_cycle();
      drive_single("post_rst", 24'sd80, 24'sd120, 24'sd164, 1'b0, 1'b1, 1'b1);
      check("post_rst_y", longint'(bus.y), -2);
      next_cycle();
      repeat (2) next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lift53_pipe.md
LIFT53_PIPE -- requirements
Module: lift53_pipe

Interface
REQ-001 Parameter W, 24, signed two's-complement sample width in bits (W >= 8).
REQ-002 Parameter CNT_W, 16, width of the line sample counter.
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  input beat offered.
REQ-006 Port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-007 Port x_left  input  W  left neighbour, signed.
REQ-008 Port x_center  input  W  sample being lifted, signed.
REQ-009 Port x_right  input  W  right neighbour, signed.
REQ-010 Port step  input  1  0 = predict (odd), 1 = update (even).
REQ-011 Port fwd_res  input  1  1 = forward transform, 0 = inverse.
REQ-012 Port in_last  input  1  last sample of a line.
REQ-013 Port out_valid  output  1  result beat valid.
REQ-014 Port out_ready  input  1  downstream accepts.
REQ-015 Port y  output  W  lifted result, signed.
REQ-016 Port out_last  output  1  in_last delayed with its beat.
REQ-017 Port ovf  output  1  sticky saturation flag.
REQ-018 Port ovf_clr  input  1  synchronous clear of ovf.
REQ-019 Port line_cnt  output  CNT_W  beats output in current line.

Function
REQ-020 Predict: y = x_center -/+ floor((x_left + x_right) / 2), minus when fwd_res=1, plus when 0.
REQ-021 Update: y = x_center +/- floor((x_left + x_right + 2) / 4), plus when fwd_res=1, minus when 0.
REQ-022 Floor division by arithmetic right shift on W+2-bit signed sum; no truncation toward zero.
REQ-023 Final add/sub in W+2 bits; result saturates to [-2^(W-1), 2^(W-1)-1].
REQ-024 Any saturated beat sets ovf on its output-register load; ovf stays set until ovf_clr.
REQ-025 ovf_clr and a saturating load in the same cycle leave ovf = 1 (set wins).
REQ-026 Two-stage pipeline: S1 registers sum+rounding, center, step, fwd_res, last; S2 registers y, out_last.
REQ-027 Latency exactly 2 cycles from accepted input to out_valid with no back-pressure.
REQ-028 Throughput one beat per cycle while out_ready = 1.
REQ-029 S2 loads when !out_valid || out_ready; S1 loads when !s1_valid || S2 loads.
REQ-030 in_ready = !s1_valid || S2 loads; purely combinational from state and out_ready, not from in_valid.
REQ-031 Stall: out_valid && !out_ready holds y, out_last, out_valid stable; no beat lost or duplicated.
REQ-032 Pipeline full and out_ready low: in_ready = 0 next cycle; two beats held.
REQ-033 line_cnt increments on each output transfer; on transfer with out_last = 1 it returns to 0.
REQ-034 line_cnt wraps to 0 after 2^CNT_W - 1 without flag.
REQ-035 step/fwd_res captured per beat; mode changes between consecutive beats take effect without bubbles.

Reset
REQ-036 rst_n low asynchronously clears S1/S2 valids, out_valid=0, y=0, out_last=0, ovf=0, line_cnt=0.
REQ-037 Reset mid-stream discards all in-flight beats; first post-reset beat emerges 2 cycles after acceptance.
REQ-038 in_ready = 1 during and right after reset (empty pipeline).

Structure
REQ-039 Package lift53_pkg holds step encodings (STEP_PREDICT=0, STEP_UPDATE=1), rounding constants (0,2), shift amounts (1,2) and a saturate function.
REQ-040 One sub-module lift53_sat (W+2 to W saturation plus overflow bit); rest flat.

Verification
REQ-041 W=24, predict fwd, l=80 c=120 r=164 -> y=-2 two cycles later, ovf=0.
REQ-042 Predict inverse, l=80 c=-2 r=164 -> y=120; update fwd l=-2 c=80 r=-2 -> y=79; update inverse l=-2 c=79 r=-2 -> y=80.
REQ-043 Predict inverse, c=8388600 l=r=100 -> y=8388607, ovf=1; ovf_clr pulse -> ovf=0; l=r=-8388608 c=-8388608 update fwd -> y=-8388608, ovf=1.
REQ-044 Stream 8 beats, out_ready low cycles 3-5: in_ready drops after two held beats, outputs in order, none lost.
REQ-045 6-beat line, in_last on 6th: line_cnt 1..5 then 0 after last transfer; next line restarts at 1.
REQ-046 Assert rst_n low with 2 beats in flight: out_valid=0 immediately, no stale beat after release.
